axi_mux_rr: RTL and testbench
=============================

AXI_MUX_RR -- requirements
Module: axi_mux_rr

Interface
REQ-001 The block SHALL have parameter INPUT_NUM, default 4, meaning the number of AXI slave ports (2..16).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the outstanding-transaction order-FIFO depth per channel (power of two, ≥2).
REQ-003 The block SHALL have parameter ARB_MODE, default 1, meaning the arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 The block SHALL have port ACLK, input, 1 bit: the single clock; all state SHALL be rising-edge.
REQ-005 The block SHALL have port ARESET, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port s_axi_i, input, axi_mosi_t[INPUT_NUM]: master-side requests (AW, W, AR, BREADY, RREADY).
REQ-007 The block SHALL have port s_axi_o, output, axi_miso_t[INPUT_NUM]: ready signals and B/R responses to each master.
REQ-008 The block SHALL have port m_axi_o, output, axi_mosi_t: the request to the single downstream slave.
REQ-009 The block SHALL have port m_axi_i, input, axi_miso_t: the response from the downstream slave.

Function
REQ-010 AW and AR SHALL each have an independent arbiter; a grant SHALL be combinational, with zero cycles from s AxVALID to m AxVALID.
REQ-011 Once m AxVALID is asserted for a grant, that grant SHALL stay locked until the m AxVALID&&AxREADY handshake; payload SHALL be stable meanwhile.
REQ-012 In ARB_MODE=1, the round-robin pointer SHALL move to (granted index+1) mod INPUT_NUM only on a handshake; search starts at the pointer.
REQ-013 Only the granted s port SHALL see AxREADY = m AxREADY; all other s AxREADY SHALL be 0.
REQ-014 An AW handshake SHALL push the source index into W_FIFO and into B_FIFO (each DEPTH deep, $clog2(INPUT_NUM) wide).
REQ-015 An AR handshake SHALL push the source index into R_FIFO.
REQ-016 If W_FIFO or B_FIFO is full, m AWVALID SHALL be 0 and all s AWREADY SHALL be 0; a same-cycle pop SHALL NOT unblock a push.
REQ-017 If R_FIFO is full, AR SHALL be stalled in the same way.
REQ-018 The W path SHALL be routed from the W_FIFO head; W_FIFO SHALL pop on a W handshake with WLAST=1.
REQ-019 If W_FIFO is empty, m WVALID SHALL be 0 and all s WREADY SHALL be 0; early W data SHALL be held off, never dropped.
REQ-020 B SHALL be routed to the B_FIFO head: s[head] BVALID = m BVALID, other s BVALID = 0, m BREADY = s[head] BREADY; B_FIFO SHALL pop on a B handshake.
REQ-021 R SHALL be routed to the R_FIFO head in the same way; R_FIFO SHALL pop on an R handshake with RLAST=1.
REQ-022 If B_FIFO or R_FIFO is empty, the corresponding m xREADY SHALL be 0 and all s xVALID SHALL be 0.
REQ-023 The downstream slave SHALL return B and R in acceptance order; IDs SHALL pass unmodified.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While ARESET=1, all FIFOs SHALL be empty, the RR pointers SHALL be 0, grant locks SHALL be clear, and every VALID/READY output SHALL be 0.
REQ-026 Reset mid-burst SHALL discard all outstanding state immediately, with no completion of in-flight bursts.

Verification
REQ-027 Scenario: 4 masters assert AWVALID each cycle, ARB_MODE=1, slave always ready -> grants occur in order 0,1,2,3,0 (one per cycle).
REQ-028 Scenario: the same stimulus with ARB_MODE=0 -> master 0 is granted every time; masters 1..3 are starved.
REQ-029 Scenario: master 2 issues AW with AWLEN=3, then master 0 issues AW with AWLEN=0, and both drive W early -> four beats from master 2, then one from master 0; master 0 WREADY=0 until master 2's WLAST.
REQ-030 Scenario: DEPTH=8 with BREADY held 0 and 9 AWs issued -> 8 are accepted and the 9th sees AWREADY=0; one B handshake still leaves it blocked that cycle, and it is accepted the next cycle.
REQ-031 Scenario: ARs from masters 1 and 3 with ARLEN=1 each -> R beats go to master 1 (2 beats) then master 3, RID unchanged, other RVALID=0.
REQ-032 Scenario: ARESET pulsed during a W burst -> all outputs are 0 the same cycle; after release, a new AW from master 0 completes normally.

Source files
------------

// File: rtl/axi_mux_rr.sv
// axi_mux_rr: N-to-1 AXI4 mux with independent AW/AR arbiters and in-order W/B/R routing via source-index FIFOs.
package axi_mux_rr_pkg;
    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arvalid;
        logic        rready;
    } axi_mosi_t;
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } axi_miso_t;
endpackage

module axi_mux_rr_arb #(
    parameter int N = 4,
    parameter int MODE = 1,
    localparam int IW = $clog2(N)
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic [N-1:0]  i_req,
    input  logic          i_block,
    input  logic          i_ready,
    output logic [IW-1:0] o_sel,
    output logic          o_valid
);
    logic          r_lock;
    logic [IW-1:0] r_lock_idx, r_ptr, w_pick;
    logic [IW:0]   w_idx;
    // Descending scan so the candidate closest to the pointer is the last one written.
    always_comb begin
        w_pick = r_ptr;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IW + 1)'(k);
            if (w_idx >= (IW + 1)'(N)) w_idx = w_idx - (IW + 1)'(N);
            if (i_req[w_idx[IW-1:0]]) w_pick = w_idx[IW-1:0];
        end
    end
    assign o_sel = r_lock ? r_lock_idx : w_pick;
    assign o_valid = (r_lock || |i_req) && !i_block;
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            r_lock <= 1'b0;
            r_lock_idx <= '0;
            r_ptr <= '0;
        end else begin
            r_lock <= o_valid && !i_ready;
            if (o_valid) r_lock_idx <= o_sel;
            if (MODE == 1 && o_valid && i_ready) r_ptr <= (o_sel == IW'(N - 1)) ? '0 : o_sel + 1'b1;
        end
endmodule

module axi_mux_rr_fifo #(
    parameter int W = 2,
    parameter int D = 8,
    localparam int AW = $clog2(D)
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    logic [AW:0]  r_wptr, r_rptr;
    logic [W-1:0] r_mem [D];
    assign o_empty = r_wptr == r_rptr;
    assign o_full = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
    assign o_head = r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
        end
    always_ff @(posedge ACLK)
        if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
endmodule

module axi_mux_rr import axi_mux_rr_pkg::*; #(
    parameter int INPUT_NUM = 4,
    parameter int DEPTH = 8,
    parameter int ARB_MODE = 1
) (
    input  logic      ACLK,
    input  logic      ARESET,
    input  axi_mosi_t s_axi_i [INPUT_NUM],
    output axi_miso_t s_axi_o [INPUT_NUM],
    output axi_mosi_t m_axi_o,
    input  axi_miso_t m_axi_i
);
    localparam int IW = $clog2(INPUT_NUM);
    logic [INPUT_NUM-1:0] w_aw_req, w_ar_req;
    logic [IW-1:0] w_aw_sel, w_ar_sel, w_w_head, w_b_head, w_r_head;
    logic w_aw_valid, w_ar_valid, w_aw_hs, w_ar_hs, w_w_pop, w_b_pop, w_r_pop;
    logic w_wf_full, w_wf_empty, w_bf_full, w_bf_empty, w_rf_full, w_rf_empty;
    for (genvar g = 0; g < INPUT_NUM; g++) begin : g_req
        assign w_aw_req[g] = s_axi_i[g].awvalid;
        assign w_ar_req[g] = s_axi_i[g].arvalid;
    end
    // Reset is folded into the block inputs so no grant can surface while ARESET is high.
    axi_mux_rr_arb #(.N(INPUT_NUM), .MODE(ARB_MODE)) u_aw_arb (
        .ACLK(ACLK), .ARESET(ARESET), .i_req(w_aw_req), .i_block(ARESET || w_wf_full || w_bf_full),
        .i_ready(m_axi_i.awready), .o_sel(w_aw_sel), .o_valid(w_aw_valid));
    axi_mux_rr_arb #(.N(INPUT_NUM), .MODE(ARB_MODE)) u_ar_arb (
        .ACLK(ACLK), .ARESET(ARESET), .i_req(w_ar_req), .i_block(ARESET || w_rf_full),
        .i_ready(m_axi_i.arready), .o_sel(w_ar_sel), .o_valid(w_ar_valid));
    assign w_aw_hs = w_aw_valid && m_axi_i.awready;
    assign w_ar_hs = w_ar_valid && m_axi_i.arready;
    assign w_w_pop = m_axi_o.wvalid && m_axi_i.wready && m_axi_o.wlast;
    assign w_b_pop = m_axi_i.bvalid && m_axi_o.bready;
    assign w_r_pop = m_axi_i.rvalid && m_axi_o.rready && m_axi_i.rlast;
    axi_mux_rr_fifo #(.W(IW), .D(DEPTH)) u_w_fifo (.ACLK(ACLK), .ARESET(ARESET), .i_push(w_aw_hs),
        .i_pop(w_w_pop), .i_data(w_aw_sel), .o_head(w_w_head), .o_full(w_wf_full), .o_empty(w_wf_empty));
    axi_mux_rr_fifo #(.W(IW), .D(DEPTH)) u_b_fifo (.ACLK(ACLK), .ARESET(ARESET), .i_push(w_aw_hs),
        .i_pop(w_b_pop), .i_data(w_aw_sel), .o_head(w_b_head), .o_full(w_bf_full), .o_empty(w_bf_empty));
    axi_mux_rr_fifo #(.W(IW), .D(DEPTH)) u_r_fifo (.ACLK(ACLK), .ARESET(ARESET), .i_push(w_ar_hs),
        .i_pop(w_r_pop), .i_data(w_ar_sel), .o_head(w_r_head), .o_full(w_rf_full), .o_empty(w_rf_empty));
    always_comb begin
        m_axi_o = '0;
        m_axi_o.awid = s_axi_i[w_aw_sel].awid;
        m_axi_o.awaddr = s_axi_i[w_aw_sel].awaddr;
        m_axi_o.awlen = s_axi_i[w_aw_sel].awlen;
        m_axi_o.awvalid = w_aw_valid;
        m_axi_o.wdata = s_axi_i[w_w_head].wdata;
        m_axi_o.wstrb = s_axi_i[w_w_head].wstrb;
        m_axi_o.wlast = s_axi_i[w_w_head].wlast;
        m_axi_o.wvalid = !w_wf_empty && s_axi_i[w_w_head].wvalid;
        m_axi_o.bready = !w_bf_empty && s_axi_i[w_b_head].bready;
        m_axi_o.arid = s_axi_i[w_ar_sel].arid;
        m_axi_o.araddr = s_axi_i[w_ar_sel].araddr;
        m_axi_o.arlen = s_axi_i[w_ar_sel].arlen;
        m_axi_o.arvalid = w_ar_valid;
        m_axi_o.rready = !w_rf_empty && s_axi_i[w_r_head].rready;
    end
    always_comb
        for (int i = 0; i < INPUT_NUM; i++) begin
            s_axi_o[i] = '0;
            s_axi_o[i].awready = w_aw_valid && w_aw_sel == IW'(i) && m_axi_i.awready;
            s_axi_o[i].wready = !w_wf_empty && w_w_head == IW'(i) && m_axi_i.wready;
            s_axi_o[i].bid = m_axi_i.bid;
            s_axi_o[i].bresp = m_axi_i.bresp;
            s_axi_o[i].bvalid = !w_bf_empty && w_b_head == IW'(i) && m_axi_i.bvalid;
            s_axi_o[i].arready = w_ar_valid && w_ar_sel == IW'(i) && m_axi_i.arready;
            s_axi_o[i].rid = m_axi_i.rid;
            s_axi_o[i].rdata = m_axi_i.rdata;
            s_axi_o[i].rresp = m_axi_i.rresp;
            s_axi_o[i].rlast = m_axi_i.rlast;
            s_axi_o[i].rvalid = !w_rf_empty && w_r_head == IW'(i) && m_axi_i.rvalid;
        end
endmodule

// File: tb/tb_axi_mux_rr.sv
// tb_axi_mux_rr: directed scenarios feed expected-value queues; a negedge monitor pops and compares on every handshake.
module tb_axi_mux_rr;
    import axi_mux_rr_pkg::*;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    axi_mosi_t s_in [4];
    axi_miso_t s_out [4], f_out [4];
    axi_mosi_t m_out, f_m_out;
    axi_miso_t m_in;
    int errors = 0;
    int checks = 0;
    int exp_aw[$], exp_fp[$], exp_w[$], exp_b[$], exp_ar[$], exp_r[$];
    logic fp_on = 1'b0;

    always #5 ACLK = ~ACLK;

    axi_mux_rr #(.INPUT_NUM(4), .DEPTH(8), .ARB_MODE(1)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi_i(s_in), .s_axi_o(s_out), .m_axi_o(m_out), .m_axi_i(m_in));
    axi_mux_rr #(.INPUT_NUM(4), .DEPTH(8), .ARB_MODE(0)) u_fp (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi_i(s_in), .s_axi_o(f_out), .m_axi_o(f_m_out), .m_axi_i(m_in));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int who(input logic [3:0] v);
        int r;
        r = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) s_in[i] = '0;
        m_in = '0;
    endtask

    task automatic pending(input string name);
        chk(name, exp_aw.size() + exp_fp.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size(), 0);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        idle();
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    // Monitor: any handshake seen on either side must match the head of its expected queue.
    always @(negedge ACLK) begin
        logic [3:0] v_aw, v_fp, v_w, v_b, v_ar, v_r;
        int p;
        for (int i = 0; i < 4; i++) begin
            v_aw[i] = s_out[i].awready;
            v_fp[i] = f_out[i].awready;
            v_w[i] = s_out[i].wready && s_in[i].wvalid;
            v_b[i] = s_out[i].bvalid && s_in[i].bready;
            v_ar[i] = s_out[i].arready;
            v_r[i] = s_out[i].rvalid && s_in[i].rready;
        end
        if ((m_out.awvalid && m_in.awready) || |v_aw)
            chk("aw_grant", who(v_aw) * 256 + int'(m_out.awid), exp_aw.size() > 0 ? exp_aw.pop_front() : -2);
        if (fp_on && ((f_m_out.awvalid && m_in.awready) || |v_fp))
            chk("fp_grant", who(v_fp) * 256 + int'(f_m_out.awid), exp_fp.size() > 0 ? exp_fp.pop_front() : -2);
        if ((m_out.wvalid && m_in.wready) || |v_w)
            chk("w_beat", who(v_w) * 1024 + int'(m_out.wlast) * 256 + int'(m_out.wdata[7:0]),
                exp_w.size() > 0 ? exp_w.pop_front() : -2);
        p = who(v_b);
        if ((m_in.bvalid && m_out.bready) || |v_b)
            chk("b_route", p * 256 + (p >= 0 ? int'(s_out[p].bid) : 0), exp_b.size() > 0 ? exp_b.pop_front() : -2);
        if ((m_out.arvalid && m_in.arready) || |v_ar)
            chk("ar_grant", who(v_ar) * 256 + int'(m_out.arid), exp_ar.size() > 0 ? exp_ar.pop_front() : -2);
        p = who(v_r);
        if ((m_in.rvalid && m_out.rready) || |v_r)
            chk("r_route", p * 65536 + (p >= 0 ? int'({s_out[p].rid, 3'b000, s_out[p].rlast, s_out[p].rdata[7:0]}) : 0),
                exp_r.size() > 0 ? exp_r.pop_front() : -2);
    end

    initial begin
        logic h0, h2;
        int beat2;
        idle();
        s_in[0].awvalid = 1'b1;
        s_in[0].wvalid = 1'b1;
        s_in[0].bready = 1'b1;
        m_in.awready = 1'b1;
        m_in.wready = 1'b1;
        m_in.bvalid = 1'b1;
        tick();
        tick();
        chk("rst_m_awvalid", int'(m_out.awvalid), 0);
        chk("rst_s0_awready", int'(s_out[0].awready), 0);
        chk("rst_m_wvalid", int'(m_out.wvalid), 0);
        chk("rst_s0_bvalid", int'(s_out[0].bvalid), 0);
        chk("rst_m_bready", int'(m_out.bready), 0);
        idle();
        ARESET = 1'b0;

        // Four masters contend every cycle: RR rotates, fixed priority starves 1..3.
        m_in.awready = 1'b1;
        fp_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in[i].awvalid = 1'b1;
            s_in[i].awid = 4'(8 + i);
        end
        exp_aw = '{32'h008, 32'h109, 32'h20A, 32'h30B, 32'h008};
        exp_fp = '{32'h008, 32'h008, 32'h008, 32'h008, 32'h008};
        repeat (5) tick();
        for (int i = 0; i < 4; i++) s_in[i].awvalid = 1'b0;
        tick();
        fp_on = 1'b0;
        pending("pend_arb");
        do_reset();

        // Early W from two masters is released strictly in AW acceptance order.
        m_in.awready = 1'b1;
        m_in.wready = 1'b1;
        s_in[2].awvalid = 1'b1;
        s_in[2].awid = 4'd2;
        s_in[2].awlen = 8'd3;
        s_in[2].wvalid = 1'b1;
        s_in[2].wdata = 32'h20;
        s_in[0].wvalid = 1'b1;
        s_in[0].wdata = 32'h40;
        s_in[0].wlast = 1'b1;
        beat2 = 0;
        exp_aw.push_back(32'h202);
        exp_w = '{32'h820, 32'h821, 32'h822, 32'h923, 32'h140};
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                s_in[2].awvalid = 1'b0;
                s_in[0].awvalid = 1'b1;
                exp_aw.push_back(32'h000);
            end
            if (c == 2) s_in[0].awvalid = 1'b0;
            @(negedge ACLK);
            h2 = s_in[2].wvalid && s_out[2].wready;
            h0 = s_in[0].wvalid && s_out[0].wready;
            if (c == 0) chk("w_early_held", int'(s_out[2].wready), 0);
            if (c < 5) chk("w0_held", int'(s_out[0].wready), 0);
            tick();
            if (h2) begin
                beat2++;
                s_in[2].wdata = 32'h20 + 32'(beat2);
                s_in[2].wlast = beat2 == 3;
                s_in[2].wvalid = beat2 < 4;
            end
            if (h0) s_in[0].wvalid = 1'b0;
        end
        for (int i = 0; i < 4; i++) s_in[i].bready = 1'b1;
        m_in.bvalid = 1'b1;
        m_in.bid = 4'hA;
        exp_b = '{32'h20A, 32'h00B};
        tick();
        m_in.bid = 4'hB;
        tick();
        m_in.bvalid = 1'b0;
        tick();
        pending("pend_w_order");
        do_reset();

        // Two single-burst reads; R beats follow AR acceptance order.
        m_in.arready = 1'b1;
        s_in[1].arvalid = 1'b1;
        s_in[1].arid = 4'd7;
        s_in[1].arlen = 8'd1;
        s_in[3].arvalid = 1'b1;
        s_in[3].arid = 4'd9;
        s_in[3].arlen = 8'd1;
        exp_ar = '{32'h107, 32'h309};
        exp_r = '{32'h17010, 32'h17111, 32'h39030, 32'h39131};
        tick();
        s_in[1].arvalid = 1'b0;
        tick();
        s_in[3].arvalid = 1'b0;
        for (int i = 0; i < 4; i++) s_in[i].rready = 1'b1;
        m_in.rvalid = 1'b1;
        m_in.rid = 4'd7;
        m_in.rdata = 32'h10;
        tick();
        m_in.rdata = 32'h11;
        m_in.rlast = 1'b1;
        tick();
        m_in.rid = 4'd9;
        m_in.rdata = 32'h30;
        m_in.rlast = 1'b0;
        tick();
        m_in.rdata = 32'h31;
        m_in.rlast = 1'b1;
        tick();
        m_in.rvalid = 1'b0;
        tick();
        pending("pend_r");
        do_reset();

        // B FIFO fills at 8; a B pop does not admit the 9th AW until the following cycle.
        m_in.awready = 1'b1;
        m_in.wready = 1'b1;
        s_in[0].awvalid = 1'b1;
        s_in[0].awid = 4'd1;
        s_in[0].wvalid = 1'b1;
        s_in[0].wlast = 1'b1;
        s_in[0].wdata = 32'h55;
        for (int i = 0; i < 9; i++) begin
            exp_aw.push_back(32'h001);
            exp_w.push_back(32'h155);
        end
        repeat (8) tick();
        chk("full_awready", int'(s_out[0].awready), 0);
        chk("full_m_awvalid", int'(m_out.awvalid), 0);
        tick();
        m_in.bvalid = 1'b1;
        m_in.bid = 4'd1;
        s_in[0].bready = 1'b1;
        exp_b.push_back(32'h001);
        #1;
        chk("bpop_m_bready", int'(m_out.bready), 1);
        chk("bpop_still_blocked", int'(s_out[0].awready), 0);
        tick();
        m_in.bvalid = 1'b0;
        #1;
        chk("unblocked_awready", int'(s_out[0].awready), 1);
        tick();
        s_in[0].awvalid = 1'b0;
        repeat (2) tick();
        pending("pend_full");
        do_reset();

        // Reset mid-burst drops everything at once; a fresh write then completes.
        m_in.awready = 1'b1;
        m_in.wready = 1'b1;
        s_in[0].awvalid = 1'b1;
        s_in[0].awid = 4'd3;
        s_in[0].awlen = 8'd3;
        s_in[0].wvalid = 1'b1;
        s_in[0].wdata = 32'h60;
        exp_aw.push_back(32'h003);
        exp_w = '{32'h060, 32'h061};
        tick();
        s_in[0].awvalid = 1'b0;
        tick();
        s_in[0].wdata = 32'h61;
        tick();
        s_in[0].wdata = 32'h62;
        s_in[0].awvalid = 1'b1;
        s_in[0].bready = 1'b1;
        m_in.bvalid = 1'b1;
        ARESET = 1'b1;
        #1;
        chk("midrst_m_wvalid", int'(m_out.wvalid), 0);
        chk("midrst_s0_wready", int'(s_out[0].wready), 0);
        chk("midrst_m_awvalid", int'(m_out.awvalid), 0);
        chk("midrst_s0_bvalid", int'(s_out[0].bvalid), 0);
        chk("midrst_m_bready", int'(m_out.bready), 0);
        pending("pend_pre_rst");
        tick();
        idle();
        ARESET = 1'b0;
        m_in.awready = 1'b1;
        m_in.wready = 1'b1;
        s_in[0].awvalid = 1'b1;
        s_in[0].awid = 4'd5;
        s_in[0].wvalid = 1'b1;
        s_in[0].wlast = 1'b1;
        s_in[0].wdata = 32'h70;
        exp_aw.push_back(32'h005);
        exp_w.push_back(32'h170);
        tick();
        s_in[0].awvalid = 1'b0;
        tick();
        s_in[0].wvalid = 1'b0;
        s_in[0].bready = 1'b1;
        m_in.bvalid = 1'b1;
        m_in.bid = 4'd5;
        exp_b.push_back(32'h005);
        tick();
        m_in.bvalid = 1'b0;
        tick();
        pending("pend_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
